// File: rtl/fp_execute_stage4_pkg.sv
// Shared FP pipeline types and constants for the fx4 normalization stage.
package fp_execute_stage4_pkg;
    localparam int VECTOR_LANES  = 16;
    localparam int FP_EXP_BIAS   = 127;
    localparam int FP_EXP_MAX    = 255;
    localparam int FP_FRAC_WIDTH = 23;

    typedef logic [31:0]             scalar_t;
    typedef logic [VECTOR_LANES-1:0] vector_lane_mask_t;
    typedef logic [1:0]              thread_idx_t;
    typedef logic [3:0]              subcycle_t;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_FTOI = 6'h1b,
        OP_FADD = 6'h20,
        OP_FSUB = 6'h21,
        OP_FMUL = 6'h22,
        OP_ITOF = 6'h2a
    } alu_op_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       has_dest;
        logic       dest_is_vector;
        logic [4:0] dest_reg;
        scalar_t    immediate_value;
    } decoded_instruction_t;

    // Ops whose result comes out of the add/sub normalization path.
    function automatic logic is_add_path_op(alu_op_t op);
        return (op == OP_FADD) || (op == OP_FSUB) || (op == OP_ITOF);
    endfunction
endpackage

// File: rtl/fp_lzc32.sv
// Combinational 32-bit count-leading-zeros; returns 32 for a zero input.
module fp_lzc32 (
    input  logic [31:0] value_i,
    output logic [5:0]  count_o
);
    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        count_o = 6'd32;
        for (int b = 0; b < 32; b++)
            if (value_i[b]) count_o = 6'(31 - b);
    end
endmodule

// File: rtl/fp_execute_stage4.sv
// FP stage 4: normalizes add/sub/itof sums and multiply products, one-cycle latency.
// Optional gradual underflow instead of flush-to-zero when FP_DENORMAL_EN is defined.
module fp_execute_stage4
    import fp_execute_stage4_pkg::*;
#(
    parameter int LANES = VECTOR_LANES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fx3_instruction_valid,
    input  decoded_instruction_t        fx3_instruction,
    input  vector_lane_mask_t           fx3_mask_value,
    input  thread_idx_t                 fx3_thread_idx,
    input  subcycle_t                   fx3_subcycle,
    input  logic [LANES-1:0]            fx3_result_is_inf,
    input  logic [LANES-1:0]            fx3_result_is_nan,
    input  logic [LANES-1:0][5:0]       fx3_ftoi_lshift,
    input  logic [LANES-1:0][31:0]      fx3_add_significand,
    input  logic [LANES-1:0][7:0]       fx3_add_exponent,
    input  logic [LANES-1:0]            fx3_add_result_sign,
    input  logic [LANES-1:0]            fx3_logical_subtract,
    input  logic [LANES-1:0][63:0]      fx3_significand_product,
    input  logic [LANES-1:0][7:0]       fx3_mul_exponent,
    input  logic [LANES-1:0]            fx3_mul_sign,
    input  logic                        wb_rollback_en,
    input  thread_idx_t                 wb_rollback_thread_idx,
    output logic                        fx4_instruction_valid,
    output decoded_instruction_t        fx4_instruction,
    output vector_lane_mask_t           fx4_mask_value,
    output thread_idx_t                 fx4_thread_idx,
    output subcycle_t                   fx4_subcycle,
    output logic [LANES-1:0]            fx4_result_is_inf,
    output logic [LANES-1:0]            fx4_result_is_nan,
    output logic [LANES-1:0][5:0]       fx4_ftoi_lshift,
    output logic [LANES-1:0][22:0]      fx4_add_significand,
    output logic [LANES-1:0][7:0]       fx4_add_exponent,
    output logic [LANES-1:0]            fx4_add_result_sign,
    output logic [LANES-1:0]            fx4_add_zero,
    output logic [LANES-1:0][31:0]      fx4_ftoi_value,
    output logic [LANES-1:0][22:0]      fx4_mul_significand,
    output logic [LANES-1:0][7:0]       fx4_mul_exponent,
    output logic [LANES-1:0]            fx4_mul_sign
);
    logic                    add_op, mul_op, squash;
    logic [LANES-1:0][22:0]  add_frac_d, mul_frac_d;
    logic [LANES-1:0][7:0]   add_exp_d, mul_exp_d;
    logic [LANES-1:0]        add_zero_d, add_sign_d, inf_d;

    assign add_op = is_add_path_op(fx3_instruction.alu_op);
    assign mul_op = (fx3_instruction.alu_op == OP_FMUL);
    assign squash = wb_rollback_en && (wb_rollback_thread_idx == fx3_thread_idx);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [5:0]        lz;
        logic signed [9:0] add_exp_raw;
        logic [31:0]       add_norm;
        logic [22:0]       a_frac;
        logic [7:0]        a_exp;
        logic              a_zero, a_sign, a_ovf;
        logic [47:0]       prod;
        logic [8:0]        m_exp_raw;
        logic [22:0]       m_frac;
        logic [7:0]        m_exp;
        logic              m_ovf;
        logic              unused_bits;

        fp_lzc32 u_lzc (
            .value_i (fx3_add_significand[i]),
            .count_o (lz)
        );

        assign add_norm    = fx3_add_significand[i] << lz;
        // Leading one nominally at bit 23, so a shift of 8 leaves the exponent unchanged.
        assign add_exp_raw = $signed({2'b00, fx3_add_exponent[i]}) + 10'sd8
                           - $signed({4'b0000, lz});

`ifdef FP_DENORMAL_EN
        logic [31:0] den_norm;
        assign den_norm = fx3_add_significand[i] << (fx3_add_exponent[i][5:0] + 6'd7);
`endif

        always_comb begin
            a_frac = add_norm[30:8];
            a_exp  = add_exp_raw[7:0];
            a_zero = 1'b0;
            a_sign = fx3_add_result_sign[i];
            a_ovf  = 1'b0;
            if (lz == 6'd32) begin
                a_frac = '0;
                a_exp  = '0;
                a_zero = 1'b1;
                a_sign = fx3_add_result_sign[i] & ~fx3_logical_subtract[i];
            end else if (add_exp_raw <= 10'sd0) begin
`ifdef FP_DENORMAL_EN
                a_frac = den_norm[30:8];
                a_exp  = '0;
                a_zero = (den_norm[30:8] == '0);
`else
                a_frac = '0;
                a_exp  = '0;
                a_zero = 1'b1;
`endif
            end else if (add_exp_raw >= 10'sd255) begin
                a_frac = '0;
                a_exp  = 8'd255;
                a_ovf  = 1'b1;
            end
        end

        assign prod      = fx3_significand_product[i][47:0];
        assign m_exp_raw = {1'b0, fx3_mul_exponent[i]} + {8'd0, prod[47]};

        always_comb begin
            m_frac = prod[47] ? prod[46:24] : prod[45:23];
            m_exp  = m_exp_raw[7:0];
            m_ovf  = 1'b0;
            if (prod == '0 || (fx3_mul_exponent[i] == 8'd0 && !prod[47])) begin
`ifdef FP_DENORMAL_EN
                m_frac = prod[46:24];
`else
                m_frac = '0;
`endif
                m_exp  = '0;
            end else if (m_exp_raw > 9'd254) begin
                m_frac = '0;
                m_exp  = 8'd255;
                m_ovf  = 1'b1;
            end
        end

        assign unused_bits   = ^{fx3_significand_product[i][63:48], prod[22:0],
                                 add_norm[31], add_norm[7:0]};
        assign add_frac_d[i] = a_frac;
        assign add_exp_d[i]  = a_exp;
        assign add_zero_d[i] = a_zero;
        assign add_sign_d[i] = a_sign;
        assign mul_frac_d[i] = m_frac;
        assign mul_exp_d[i]  = m_exp;
        // A NaN lane keeps its incoming flags untouched.
        assign inf_d[i] = fx3_result_is_nan[i] ? fx3_result_is_inf[i]
                        : (fx3_result_is_inf[i] | (add_op & a_ovf) | (mul_op & m_ovf));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fx4_instruction_valid <= 1'b0;
            fx4_instruction       <= '0;
            fx4_mask_value        <= '0;
            fx4_thread_idx        <= '0;
            fx4_subcycle          <= '0;
        end else begin
            fx4_instruction_valid <= fx3_instruction_valid && !squash;
            fx4_instruction       <= fx3_instruction;
            fx4_mask_value        <= fx3_mask_value;
            fx4_thread_idx        <= fx3_thread_idx;
            fx4_subcycle          <= fx3_subcycle;
        end
    end

    always_ff @(posedge clk) begin
        fx4_result_is_inf   <= inf_d;
        fx4_result_is_nan   <= fx3_result_is_nan;
        fx4_ftoi_lshift     <= fx3_ftoi_lshift;
        fx4_add_significand <= add_frac_d;
        fx4_add_exponent    <= add_exp_d;
        fx4_add_result_sign <= add_sign_d;
        fx4_add_zero        <= add_zero_d;
        fx4_ftoi_value      <= fx3_add_significand;
        fx4_mul_significand <= mul_frac_d;
        fx4_mul_exponent    <= mul_exp_d;
        fx4_mul_sign        <= fx3_mul_sign;
    end
endmodule

// File: tb/tb_fp_execute_stage4.sv
// Self-checking bench for fp_execute_stage4: directed boundary cases plus a random reference-model run.
module tb_fp_execute_stage4;
    import fp_execute_stage4_pkg::*;
    localparam int L = VECTOR_LANES;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   fx3_instruction_valid;
    decoded_instruction_t   fx3_instruction;
    vector_lane_mask_t      fx3_mask_value;
    thread_idx_t            fx3_thread_idx;
    subcycle_t              fx3_subcycle;
    logic [L-1:0]           fx3_result_is_inf, fx3_result_is_nan;
    logic [L-1:0][5:0]      fx3_ftoi_lshift;
    logic [L-1:0][31:0]     fx3_add_significand;
    logic [L-1:0][7:0]      fx3_add_exponent;
    logic [L-1:0]           fx3_add_result_sign, fx3_logical_subtract;
    logic [L-1:0][63:0]     fx3_significand_product;
    logic [L-1:0][7:0]      fx3_mul_exponent;
    logic [L-1:0]           fx3_mul_sign;
    logic                   wb_rollback_en;
    thread_idx_t            wb_rollback_thread_idx;
    logic                   fx4_instruction_valid;
    decoded_instruction_t   fx4_instruction;
    vector_lane_mask_t      fx4_mask_value;
    thread_idx_t            fx4_thread_idx;
    subcycle_t              fx4_subcycle;
    logic [L-1:0]           fx4_result_is_inf, fx4_result_is_nan;
    logic [L-1:0][5:0]      fx4_ftoi_lshift;
    logic [L-1:0][22:0]     fx4_add_significand;
    logic [L-1:0][7:0]      fx4_add_exponent;
    logic [L-1:0]           fx4_add_result_sign, fx4_add_zero;
    logic [L-1:0][31:0]     fx4_ftoi_value;
    logic [L-1:0][22:0]     fx4_mul_significand;
    logic [L-1:0][7:0]      fx4_mul_exponent;
    logic [L-1:0]           fx4_mul_sign;

    int checks = 0;
    int fails  = 0;

    fp_execute_stage4 #(.LANES(L)) dut (
        .clk(clk), .reset(reset),
        .fx3_instruction_valid(fx3_instruction_valid), .fx3_instruction(fx3_instruction),
        .fx3_mask_value(fx3_mask_value), .fx3_thread_idx(fx3_thread_idx),
        .fx3_subcycle(fx3_subcycle), .fx3_result_is_inf(fx3_result_is_inf),
        .fx3_result_is_nan(fx3_result_is_nan), .fx3_ftoi_lshift(fx3_ftoi_lshift),
        .fx3_add_significand(fx3_add_significand), .fx3_add_exponent(fx3_add_exponent),
        .fx3_add_result_sign(fx3_add_result_sign), .fx3_logical_subtract(fx3_logical_subtract),
        .fx3_significand_product(fx3_significand_product), .fx3_mul_exponent(fx3_mul_exponent),
        .fx3_mul_sign(fx3_mul_sign), .wb_rollback_en(wb_rollback_en),
        .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .fx4_instruction_valid(fx4_instruction_valid), .fx4_instruction(fx4_instruction),
        .fx4_mask_value(fx4_mask_value), .fx4_thread_idx(fx4_thread_idx),
        .fx4_subcycle(fx4_subcycle), .fx4_result_is_inf(fx4_result_is_inf),
        .fx4_result_is_nan(fx4_result_is_nan), .fx4_ftoi_lshift(fx4_ftoi_lshift),
        .fx4_add_significand(fx4_add_significand), .fx4_add_exponent(fx4_add_exponent),
        .fx4_add_result_sign(fx4_add_result_sign), .fx4_add_zero(fx4_add_zero),
        .fx4_ftoi_value(fx4_ftoi_value), .fx4_mul_significand(fx4_mul_significand),
        .fx4_mul_exponent(fx4_mul_exponent), .fx4_mul_sign(fx4_mul_sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] af;
        logic [7:0]  ae;
        logic        as, az, inf, nan;
        logic [22:0] mf;
        logic [7:0]  me;
    } exp_t;

    // Reference model: value-level rules for one lane from the current stimulus.
    function automatic exp_t ref_lane(input int l);
        exp_t        r;
        logic [31:0] sig, n;
        logic [47:0] p;
        int          lz, e;
        logic        ao, mo, addop;
        sig = fx3_add_significand[l];
        p   = fx3_significand_product[l][47:0];
        ao = 1'b0; mo = 1'b0;
        lz = 0;
        while (lz < 32 && !sig[31-lz]) lz++;
        e = int'(fx3_add_exponent[l]) + 8 - lz;
        r.as = fx3_add_result_sign[l];
        r.az = 1'b0;
        if (lz == 32) begin
            r.af = 0; r.ae = 0; r.az = 1'b1;
            r.as = fx3_add_result_sign[l] && !fx3_logical_subtract[l];
        end else if (e <= 0) begin
`ifdef FP_DENORMAL_EN
            n = sig << (int'(fx3_add_exponent[l]) + 7);
            r.af = n[30:8]; r.ae = 0; r.az = (n[30:8] == 0);
`else
            r.af = 0; r.ae = 0; r.az = 1'b1;
`endif
        end else if (e >= 255) begin
            r.af = 0; r.ae = 8'd255; ao = 1'b1;
        end else begin
            n = sig << lz;
            r.af = n[30:8]; r.ae = 8'(e);
        end
        if (p == 0 || (fx3_mul_exponent[l] == 0 && !p[47])) begin
`ifdef FP_DENORMAL_EN
            r.mf = p[46:24];
`else
            r.mf = 0;
`endif
            r.me = 0;
        end else begin
            e = int'(fx3_mul_exponent[l]) + (p[47] ? 1 : 0);
            if (e > 254) begin
                r.mf = 0; r.me = 8'd255; mo = 1'b1;
            end else begin
                r.mf = p[47] ? p[46:24] : p[45:23];
                r.me = 8'(e);
            end
        end
        addop = (fx3_instruction.alu_op inside {OP_FADD, OP_FSUB, OP_ITOF});
        r.nan = fx3_result_is_nan[l];
        r.inf = fx3_result_is_nan[l] ? fx3_result_is_inf[l]
              : (fx3_result_is_inf[l] || (addop && ao) || (fx3_instruction.alu_op == OP_FMUL && mo));
        return r;
    endfunction

    task automatic clear_inputs();
        fx3_instruction_valid   = 1'b0;
        fx3_instruction         = '0;
        fx3_mask_value          = '1;
        fx3_thread_idx          = '0;
        fx3_subcycle            = '0;
        fx3_result_is_inf       = '0;
        fx3_result_is_nan       = '0;
        fx3_ftoi_lshift         = '0;
        fx3_add_significand     = '0;
        fx3_add_exponent        = '0;
        fx3_add_result_sign     = '0;
        fx3_logical_subtract    = '0;
        fx3_significand_product = '0;
        fx3_mul_exponent        = '0;
        fx3_mul_sign            = '0;
        wb_rollback_en          = 1'b0;
        wb_rollback_thread_idx  = '0;
    endtask

    task automatic randomize_inputs();
        alu_op_t     ops [5];
        logic [63:0] r64;
        logic [47:0] t;
        logic [7:0]  edges [7];
        ops   = '{OP_FADD, OP_FSUB, OP_FMUL, OP_ITOF, OP_FTOI};
        edges = '{8'd0, 8'd1, 8'd3, 8'd127, 8'd253, 8'd254, 8'd255};
        fx3_instruction_valid = 1'($urandom_range(0, 1));
        fx3_instruction.alu_op = ops[$urandom_range(0, 4)];
        fx3_instruction.has_dest = 1'($urandom);
        fx3_instruction.dest_is_vector = 1'($urandom);
        fx3_instruction.dest_reg = 5'($urandom);
        fx3_instruction.immediate_value = $urandom;
        fx3_mask_value = 16'($urandom);
        fx3_thread_idx = 2'($urandom);
        fx3_subcycle   = 4'($urandom);
        wb_rollback_en = ($urandom_range(0, 3) == 0);
        wb_rollback_thread_idx = 2'($urandom);
        for (int l = 0; l < L; l++) begin
            case ($urandom_range(0, 7))
                0:       fx3_add_significand[l] = 32'h0;
                1:       fx3_add_significand[l] = 32'h0100_0000 | ($urandom & 32'h00FF_FFFF);
                default: fx3_add_significand[l] = $urandom >> $urandom_range(0, 31);
            endcase
            fx3_add_exponent[l] = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 6)]
                                                              : 8'($urandom);
            fx3_add_result_sign[l]  = 1'($urandom);
            fx3_logical_subtract[l] = 1'($urandom);
            r64 = {$urandom, $urandom};
            t = r64[47:0];
            t[47] = 1'b1;
            if ($urandom_range(0, 1) == 1) t = t >> 1;
            if ($urandom_range(0, 9) == 0) t = '0;
            fx3_significand_product[l] = {r64[63:48], t};
            fx3_mul_exponent[l] = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 6)]
                                                              : 8'($urandom);
            fx3_mul_sign[l]      = 1'($urandom);
            fx3_result_is_inf[l] = ($urandom_range(0, 9) == 0);
            fx3_result_is_nan[l] = ($urandom_range(0, 9) == 0);
            fx3_ftoi_lshift[l]   = 6'($urandom);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        randomize_inputs();
        fx3_instruction_valid = 1'b1;
        wb_rollback_en = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (fx4_instruction_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", fx4_instruction_valid);
        end
        checks++;
        if ({fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle} !== '0) begin
            fails++; $display("FAIL reset_ctrl: got %h want 0",
                              {fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle});
        end
        reset = 1'b0;
    endtask

    task automatic test_add_directed();
        logic [31:0] sig [9];
        logic [7:0]  ex [9];
        logic        sg [9], ls [9];
        logic [22:0] wf [9];
        logic [7:0]  we [9];
        logic        wz [9], ws [9], wi [9];
        sig = '{32'h0100_0000, 32'h0000_0001, 32'h0, 32'h0000_0100, 32'h00C0_0000,
                32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0080_0000};
        ex  = '{8'd127, 8'd127, 8'd127, 8'd3, 8'd100, 8'd254, 8'd253, 8'd0, 8'd0};
        sg  = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        ls  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        wf  = '{23'h0, 23'h0, 23'h0, 23'h0, 23'h400000, 23'h0, 23'h0, 23'h0, 23'h0};
        we  = '{8'd128, 8'd104, 8'd0, 8'd0, 8'd100, 8'd255, 8'd254, 8'd0, 8'd0};
        wz  = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
        ws  = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
        wi  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
`ifdef FP_DENORMAL_EN
        wf[3] = 23'h000400; wz[3] = 1'b0;
        wf[8] = 23'h400000; wz[8] = 1'b0;
`endif
        clear_inputs();
        fx3_instruction_valid = 1'b1;
        fx3_instruction.alu_op = OP_FADD;
        for (int l = 0; l < 9; l++) begin
            fx3_add_significand[l] = sig[l];
            fx3_add_exponent[l]    = ex[l];
            fx3_add_result_sign[l] = sg[l];
            fx3_logical_subtract[l] = ls[l];
        end
        @(posedge clk); #1;
        for (int l = 0; l < 9; l++) begin
            checks++;
            if ({fx4_add_significand[l], fx4_add_exponent[l]} !== {wf[l], we[l]}) begin
                fails++; $display("FAIL add_frac_exp lane %0d: got %h/%0d want %h/%0d", l,
                                  fx4_add_significand[l], fx4_add_exponent[l], wf[l], we[l]);
            end
            checks++;
            if ({fx4_add_zero[l], fx4_add_result_sign[l], fx4_result_is_inf[l]} !== {wz[l], ws[l], wi[l]}) begin
                fails++; $display("FAIL add_zero_sign_inf lane %0d: got %b%b%b want %b%b%b", l,
                                  fx4_add_zero[l], fx4_add_result_sign[l], fx4_result_is_inf[l],
                                  wz[l], ws[l], wi[l]);
            end
        end
    endtask

    task automatic test_mul_directed();
        logic [47:0] pr [10];
        logic [7:0]  ex [10];
        logic [22:0] wf [10];
        logic [7:0]  we [10];
        logic        wi [10], nin [10], iin [10];
        pr  = '{48'hC000_0000_0000, 48'hC000_0000_0000, 48'h4000_0000_0000, 48'h6000_0000_0000,
                48'h0, 48'h4000_0000_0000, 48'h8000_0000_0000, 48'h4000_0000_0000,
                48'hC000_0000_0000, 48'h4000_0000_0000};
        ex  = '{8'd127, 8'd254, 8'd127, 8'd10, 8'd100, 8'd0, 8'd0, 8'd255, 8'd254, 8'd50};
        wf  = '{23'h400000, 23'h0, 23'h0, 23'h400000, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
        we  = '{8'd128, 8'd255, 8'd127, 8'd10, 8'd0, 8'd0, 8'd1, 8'd255, 8'd255, 8'd50};
        wi  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        nin = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        iin = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`ifdef FP_DENORMAL_EN
        wf[5] = 23'h400000;
`endif
        clear_inputs();
        fx3_instruction_valid = 1'b1;
        fx3_instruction.alu_op = OP_FMUL;
        for (int l = 0; l < 10; l++) begin
            fx3_significand_product[l] = {16'hDEAD, pr[l]};
            fx3_mul_exponent[l]  = ex[l];
            fx3_mul_sign[l]      = 1'(l);
            fx3_result_is_nan[l] = nin[l];
            fx3_result_is_inf[l] = iin[l];
        end
        @(posedge clk); #1;
        for (int l = 0; l < 10; l++) begin
            checks++;
            if ({fx4_mul_significand[l], fx4_mul_exponent[l]} !== {wf[l], we[l]}) begin
                fails++; $display("FAIL mul_frac_exp lane %0d: got %h/%0d want %h/%0d", l,
                                  fx4_mul_significand[l], fx4_mul_exponent[l], wf[l], we[l]);
            end
            checks++;
            if ({fx4_result_is_inf[l], fx4_result_is_nan[l], fx4_mul_sign[l]} !== {wi[l], nin[l], 1'(l)}) begin
                fails++; $display("FAIL mul_flags lane %0d: got %b%b%b want %b%b%b", l,
                                  fx4_result_is_inf[l], fx4_result_is_nan[l], fx4_mul_sign[l],
                                  wi[l], nin[l], 1'(l));
            end
        end
    endtask

    task automatic test_rollback();
        thread_idx_t rb [3];
        logic        en [3], wv [3];
        rb = '{2'd2, 2'd1, 2'd2};
        en = '{1, 1, 0};
        wv = '{0, 1, 1};
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            fx3_instruction_valid  = 1'b1;
            fx3_thread_idx         = 2'd2;
            fx3_subcycle           = 4'(k + 3);
            wb_rollback_en         = en[k];
            wb_rollback_thread_idx = rb[k];
            @(posedge clk); #1;
            checks++;
            if (fx4_instruction_valid !== wv[k]) begin
                fails++; $display("FAIL rollback_valid case %0d: got %b want %b", k, fx4_instruction_valid, wv[k]);
            end
            checks++;
            if ({fx4_thread_idx, fx4_subcycle} !== {2'd2, 4'(k + 3)}) begin
                fails++; $display("FAIL rollback_fields case %0d: got %h want %h", k,
                                  {fx4_thread_idx, fx4_subcycle}, {2'd2, 4'(k + 3)});
            end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        fx3_instruction_valid = 1'b1;
        fx3_instruction.alu_op = OP_FADD;
        fx3_instruction.dest_reg = 5'd9;
        @(posedge clk); #1;
        checks++;
        if (fx4_instruction_valid !== 1'b1) begin
            fails++; $display("FAIL pre_reset_valid: got %b want 1", fx4_instruction_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({fx4_instruction_valid, fx4_instruction} !== '0) begin
            fails++; $display("FAIL async_reset: got %h want 0", {fx4_instruction_valid, fx4_instruction});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        fx3_instruction.dest_reg = 5'd17;
        checks++;
        if (fx4_instruction_valid !== 1'b0) begin
            fails++; $display("FAIL post_reset_hold: got %b want 0", fx4_instruction_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (fx4_instruction_valid !== 1'b1 || fx4_instruction.dest_reg !== 5'd17) begin
            fails++; $display("FAIL first_after_reset: got %b/%0d want 1/17",
                              fx4_instruction_valid, fx4_instruction.dest_reg);
        end
    endtask

    task automatic test_back_to_back_random(input int n);
        exp_t r;
        logic wv;
        for (int c = 0; c < n; c++) begin
            randomize_inputs();
            wv = fx3_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == fx3_thread_idx);
            @(posedge clk); #1;
            checks++;
            if ({fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle}
                !== {wv, fx3_instruction, fx3_mask_value, fx3_thread_idx, fx3_subcycle}) begin
                fails++; $display("FAIL rnd_ctrl cycle %0d: got %h want %h", c,
                    {fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx, fx4_subcycle},
                    {wv, fx3_instruction, fx3_mask_value, fx3_thread_idx, fx3_subcycle});
            end
            for (int l = 0; l < L; l++) begin
                r = ref_lane(l);
                checks++;
                if ({fx4_add_significand[l], fx4_add_exponent[l], fx4_add_result_sign[l], fx4_add_zero[l]}
                    !== {r.af, r.ae, r.as, r.az}) begin
                    fails++; $display("FAIL rnd_add c%0d lane %0d sig %h exp %0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                        c, l, fx3_add_significand[l], fx3_add_exponent[l], fx4_add_significand[l],
                        fx4_add_exponent[l], fx4_add_result_sign[l], fx4_add_zero[l], r.af, r.ae, r.as, r.az);
                end
                checks++;
                if ({fx4_mul_significand[l], fx4_mul_exponent[l], fx4_mul_sign[l]} !== {r.mf, r.me, fx3_mul_sign[l]}) begin
                    fails++; $display("FAIL rnd_mul c%0d lane %0d prod %h exp %0d: got %h/%0d want %h/%0d",
                        c, l, fx3_significand_product[l][47:0], fx3_mul_exponent[l],
                        fx4_mul_significand[l], fx4_mul_exponent[l], r.mf, r.me);
                end
                checks++;
                if ({fx4_result_is_inf[l], fx4_result_is_nan[l]} !== {r.inf, r.nan}) begin
                    fails++; $display("FAIL rnd_flags c%0d lane %0d: got %b%b want %b%b",
                        c, l, fx4_result_is_inf[l], fx4_result_is_nan[l], r.inf, r.nan);
                end
                checks++;
                if ({fx4_ftoi_value[l], fx4_ftoi_lshift[l]} !== {fx3_add_significand[l], fx3_ftoi_lshift[l]}) begin
                    fails++; $display("FAIL rnd_ftoi c%0d lane %0d: got %h/%0d want %h/%0d", c, l,
                        fx4_ftoi_value[l], fx4_ftoi_lshift[l], fx3_add_significand[l], fx3_ftoi_lshift[l]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_directed();
        test_mul_directed();
        test_rollback();
        test_async_reset();
        test_back_to_back_random(300);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
